// File: rtl/basilisk_reg_scoreboard.sv
// Per-register pending-write scoreboard for the basilisk FP/vector register file.
// Counts issued-but-not-written-back writes and drives the decode dependency status bits.
module basilisk_reg_scoreboard #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned COUNT_WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic [4:0] query_rd_addr,
    input  logic [4:0] query_rs1_addr,
    input  logic [4:0] query_rs2_addr,
    input  logic [4:0] query_rs3_addr,
    output logic       rd_status,
    output logic       rs1_status,
    output logic       rs2_status,
    output logic       rs3_status,

    input  logic       issue_valid,
    input  logic       issue_writes_rd,
    input  logic [4:0] issue_rd_addr,

    input  logic       wb0_valid,
    input  logic [4:0] wb0_addr,
    input  logic       wb1_valid,
    input  logic [4:0] wb1_addr,

    output logic       idle,
    output logic       overflow_error,
    output logic       underflow_error
);

    localparam int unsigned SUM_W = COUNT_WIDTH + 2;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic signed [SUM_W-1:0] SUM_MAX = $signed({2'b00, CNT_MAX});
    localparam logic signed [SUM_W-1:0] SUM_ONE = $signed(SUM_W'(1));

    logic [COUNT_WIDTH-1:0] count_q [NUM_REGS];
    logic [COUNT_WIDTH-1:0] count_d [NUM_REGS];
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic signed [SUM_W-1:0] net;

    // Clamp is applied to the net of all same-cycle events, so issue+writeback cancels cleanly.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        net         = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            net = $signed({2'b00, count_q[r]});
            if (issue_valid && issue_writes_rd && (issue_rd_addr == 5'(r))) begin
                net = net + SUM_ONE;
            end
            if (wb0_valid && (wb0_addr == 5'(r))) begin
                net = net - SUM_ONE;
            end
            if (wb1_valid && (wb1_addr == 5'(r))) begin
                net = net - SUM_ONE;
            end
            if (net[SUM_W-1]) begin
                count_d[r]  = '0;
                underflow_d = 1'b1;
            end else if (net > SUM_MAX) begin
                count_d[r]  = CNT_MAX;
                overflow_d  = 1'b1;
            end else begin
                count_d[r]  = net[COUNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= '0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= count_d[r];
            end
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Out-of-range addresses match no entry and read as zero, so their status is 1.
    function automatic logic [COUNT_WIDTH-1:0] count_of(input logic [4:0] addr);
        logic [COUNT_WIDTH-1:0] c;
        c = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (addr == 5'(r)) begin
                c = count_q[r];
            end
        end
        return c;
    endfunction

    always_comb begin
        rd_status  = (count_of(query_rd_addr) != CNT_MAX);
        rs1_status = (count_of(query_rs1_addr) == '0);
        rs2_status = (count_of(query_rs2_addr) == '0);
        rs3_status = (count_of(query_rs3_addr) == '0);
    end

    always_comb begin
        idle = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (count_q[r] != '0) begin
                idle = 1'b0;
            end
        end
    end

    assign overflow_error  = overflow_q;
    assign underflow_error = underflow_q;

endmodule

// File: tb/tb_basilisk_reg_scoreboard.sv
// Directed vector bench for basilisk_reg_scoreboard: status, clamping, sticky errors, async reset.
module tb_basilisk_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] query_rd_addr, query_rs1_addr, query_rs2_addr, query_rs3_addr;
    logic       rd_status, rs1_status, rs2_status, rs3_status;
    logic       issue_valid, issue_writes_rd;
    logic [4:0] issue_rd_addr;
    logic       wb0_valid, wb1_valid;
    logic [4:0] wb0_addr, wb1_addr;
    logic       idle, overflow_error, underflow_error;

    basilisk_reg_scoreboard #(
        .NUM_REGS    (32),
        .COUNT_WIDTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .query_rd_addr   (query_rd_addr),
        .query_rs1_addr  (query_rs1_addr),
        .query_rs2_addr  (query_rs2_addr),
        .query_rs3_addr  (query_rs3_addr),
        .rd_status       (rd_status),
        .rs1_status      (rs1_status),
        .rs2_status      (rs2_status),
        .rs3_status      (rs3_status),
        .issue_valid     (issue_valid),
        .issue_writes_rd (issue_writes_rd),
        .issue_rd_addr   (issue_rd_addr),
        .wb0_valid       (wb0_valid),
        .wb0_addr        (wb0_addr),
        .wb1_valid       (wb1_valid),
        .wb1_addr        (wb1_addr),
        .idle            (idle),
        .overflow_error  (overflow_error),
        .underflow_error (underflow_error)
    );

    always #5 clk = ~clk;

    // Expected bits ordered {rd, rs1, rs2, rs3, idle, overflow, underflow}.
    typedef struct packed {
        logic       iv;
        logic       iw;
        logic [4:0] ia;
        logic       w0v;
        logic [4:0] w0a;
        logic       w1v;
        logic [4:0] w1a;
        logic [4:0] qrd;
        logic [4:0] qrs1;
        logic [4:0] qrs2;
        logic [4:0] qrs3;
        logic [6:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic iv, input logic iw, input int ia,
                                input logic w0v, input int w0a, input logic w1v, input int w1a,
                                input int qrd, input int qrs1, input int qrs2, input int qrs3,
                                input logic [6:0] exp);
        vec_t v;
        v.iv = iv;   v.iw = iw;   v.ia = 5'(ia);
        v.w0v = w0v; v.w0a = 5'(w0a);
        v.w1v = w1v; v.w1a = 5'(w1a);
        v.qrd = 5'(qrd); v.qrs1 = 5'(qrs1); v.qrs2 = 5'(qrs2); v.qrs3 = 5'(qrs3);
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] observed();
        return {rd_status, rs1_status, rs2_status, rs3_status, idle, overflow_error,
                underflow_error};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = observed();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (rd rs1 rs2 rs3 idle ovf unf)",
                     name, got, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0; issue_writes_rd = 1'b0; issue_rd_addr = '0;
        wb0_valid = 1'b0; wb0_addr = '0; wb1_valid = 1'b0; wb1_addr = '0;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 5, 9, 2, 7'b1111_1_00);
        vecs[1]  = mk(1, 1, 5, 0, 0, 0, 0, 5, 5, 9, 2, 7'b1011_0_00);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 5, 9, 2, 7'b1011_0_00);
        vecs[3]  = mk(1, 0, 9, 0, 0, 0, 0, 5, 5, 9, 2, 7'b1011_0_00);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 5, 5, 5, 9, 2, 7'b1111_1_00);
        vecs[5]  = mk(1, 1, 9, 0, 0, 0, 0, 9, 9, 5, 9, 7'b1010_0_00);
        vecs[6]  = mk(1, 1, 9, 0, 0, 0, 0, 9, 9, 5, 9, 7'b1010_0_00);
        vecs[7]  = mk(1, 1, 9, 0, 0, 0, 0, 9, 9, 5, 9, 7'b0010_0_00);
        vecs[8]  = mk(1, 1, 9, 1, 9, 0, 0, 9, 9, 5, 9, 7'b0010_0_00);
        vecs[9]  = mk(0, 0, 0, 1, 9, 1, 9, 9, 9, 5, 9, 7'b1010_0_00);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 9, 9, 9, 5, 9, 7'b1111_1_00);
        vecs[11] = mk(1, 1, 2, 1, 2, 0, 0, 2, 2, 2, 2, 7'b1111_1_00);
        vecs[12] = mk(1, 1, 7, 0, 0, 0, 0, 7, 3, 7, 0, 7'b1101_0_00);
        vecs[13] = mk(1, 1, 7, 0, 0, 0, 0, 7, 3, 7, 0, 7'b1101_0_00);
        vecs[14] = mk(1, 1, 7, 0, 0, 0, 0, 7, 3, 7, 0, 7'b0101_0_00);
        vecs[15] = mk(1, 1, 7, 0, 0, 0, 0, 7, 3, 7, 0, 7'b0101_0_10);
        vecs[16] = mk(0, 0, 0, 1, 7, 1, 7, 7, 3, 7, 0, 7'b1101_0_10);
        vecs[17] = mk(0, 0, 0, 1, 7, 0, 0, 7, 3, 7, 0, 7'b1111_1_10);
        vecs[18] = mk(0, 0, 0, 1, 2, 0, 0, 2, 2, 2, 2, 7'b1111_1_11);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 2, 7'b1111_1_11);

        drive_idle();
        query_rd_addr = 5'd5; query_rs1_addr = 5'd5; query_rs2_addr = 5'd9; query_rs3_addr = 5'd2;
        rst_n = 1'b0;
        #12;
        check("reset_state", 7'b1111_1_00);
        @(negedge clk);
        rst_n = 1'b1;

        // Each vector is driven at negedge and checked just after the edge that consumes it.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            issue_valid = vecs[i].iv; issue_writes_rd = vecs[i].iw; issue_rd_addr = vecs[i].ia;
            wb0_valid = vecs[i].w0v; wb0_addr = vecs[i].w0a;
            wb1_valid = vecs[i].w1v; wb1_addr = vecs[i].w1a;
            query_rd_addr = vecs[i].qrd; query_rs1_addr = vecs[i].qrs1;
            query_rs2_addr = vecs[i].qrs2; query_rs3_addr = vecs[i].qrs3;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // No same-cycle bypass: status before the consuming edge still shows the old count.
        @(negedge clk);
        drive_idle();
        issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_addr = 5'd3;
        query_rd_addr = 5'd3; query_rs1_addr = 5'd3; query_rs2_addr = 5'd3; query_rs3_addr = 5'd3;
        #1;
        check("no_bypass", 7'b1111_1_11);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("f3_count2", 7'b1000_0_11);

        // Asynchronous reset mid-cycle clears counters and sticky errors without a clock edge.
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 7'b1111_1_00);
        @(negedge clk);
        rst_n = 1'b1;

        // Resumes counting after reset release.
        issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_addr = 5'd3;
        @(posedge clk);
        #1;
        check("post_reset_issue", 7'b1000_0_00);
        @(negedge clk);
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
